// File: rtl/bht_predictor.sv
// Two-way set-associative branch history / target buffer with LRU replacement,
// allocate-on-taken, synchronous flush and saturating statistics counters.
module bht_predictor #(
  parameter int unsigned SETS  = 32,
  parameter int unsigned TAG_W = 20,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             lookup_valid,
  input  logic [31:0]      lookup_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_mispred,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_hits,
  output logic [CNT_W-1:0] stat_mispred
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TGT_W = 30;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Array state: valid/LRU are reset, payload storage is not.
  logic [SETS-1:0]  valid_q [2];
  logic [SETS-1:0]  valid_d [2];
  logic [SETS-1:0]  lru_q, lru_d;
  logic [TAG_W-1:0] tag_q [2][SETS];
  logic [TAG_W-1:0] tag_d [2][SETS];
  logic [1:0]       ctr_q [2][SETS];
  logic [1:0]       ctr_d [2][SETS];
  logic [TGT_W-1:0] tgt_q [2][SETS];
  logic [TGT_W-1:0] tgt_d [2][SETS];
  logic [CNT_W-1:0] hits_q, hits_d;
  logic [CNT_W-1:0] misp_q, misp_d;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit0, l_hit1, u_hit0, u_hit1, u_hit;
  logic             u_way, u_vic;
  logic [1:0]       l_ctr, u_ctr;

  // Low PC/target bits and PC bits above the tag carry no information here.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc, upd_pc, upd_target[1:0]};

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[IDX_W+2 +: TAG_W];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[IDX_W+2 +: TAG_W];

  // Combinational lookup; way 0 wins if both ways ever match.
  always_comb begin
    l_hit0      = valid_q[0][l_idx] && (tag_q[0][l_idx] == l_tag);
    l_hit1      = valid_q[1][l_idx] && (tag_q[1][l_idx] == l_tag);
    pred_hit    = l_hit0 | l_hit1;
    l_ctr       = l_hit0 ? ctr_q[0][l_idx] : ctr_q[1][l_idx];
    pred_taken  = pred_hit & l_ctr[1];
    pred_target = lookup_pc + 32'd4;
    if (pred_taken) begin
      pred_target = l_hit0 ? {tgt_q[0][l_idx], 2'b00} : {tgt_q[1][l_idx], 2'b00};
    end
  end

  // Next array state: flush, train on hit, or allocate on taken miss.
  always_comb begin
    valid_d = valid_q;
    lru_d   = lru_q;
    tag_d   = tag_q;
    ctr_d   = ctr_q;
    tgt_d   = tgt_q;
    u_hit0  = valid_q[0][u_idx] && (tag_q[0][u_idx] == u_tag);
    u_hit1  = valid_q[1][u_idx] && (tag_q[1][u_idx] == u_tag);
    u_hit   = u_hit0 | u_hit1;
    u_way   = ~u_hit0;
    u_ctr   = ctr_q[u_way][u_idx];
    if (!valid_q[0][u_idx])      u_vic = 1'b0;
    else if (!valid_q[1][u_idx]) u_vic = 1'b1;
    else                         u_vic = lru_q[u_idx];
    if (flush) begin
      valid_d[0] = '0;
      valid_d[1] = '0;
      lru_d      = '0;
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          ctr_d[u_way][u_idx] = (u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'd1;
          tgt_d[u_way][u_idx] = upd_target[31:2];
        end else begin
          ctr_d[u_way][u_idx] = (u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'd1;
        end
        lru_d[u_idx] = ~u_way;
      end else if (upd_taken) begin
        valid_d[u_vic][u_idx] = 1'b1;
        tag_d[u_vic][u_idx]   = u_tag;
        ctr_d[u_vic][u_idx]   = 2'b10;
        tgt_d[u_vic][u_idx]   = upd_target[31:2];
        lru_d[u_idx]          = ~u_vic;
      end
    end
  end

  // Saturating statistics; clear has priority over increment.
  always_comb begin
    hits_d = hits_q;
    misp_d = misp_q;
    if (stat_clr) begin
      hits_d = '0;
      misp_d = '0;
    end else begin
      if (lookup_valid && pred_hit && (hits_q != CNT_MAX)) hits_d = hits_q + CNT_W'(1);
      if (upd_valid && upd_mispred && (misp_q != CNT_MAX)) misp_d = misp_q + CNT_W'(1);
    end
  end

  // Reset-bearing state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
      hits_q     <= '0;
      misp_q     <= '0;
    end else begin
      valid_q <= valid_d;
      lru_q   <= lru_d;
      hits_q  <= hits_d;
      misp_q  <= misp_d;
    end
  end

  // Payload storage, qualified by valid so no reset needed.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    ctr_q <= ctr_d;
    tgt_q <= tgt_d;
  end

  assign stat_hits    = hits_q;
  assign stat_mispred = misp_q;

endmodule

// File: tb/tb_bht_predictor.sv
// Directed self-checking bench for bht_predictor (CNT_W=4 for saturation).
module tb_bht_predictor;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             lookup_valid;
  logic [31:0]      lookup_pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             upd_mispred;
  logic             stat_clr;
  logic [CNT_W-1:0] stat_hits;
  logic [CNT_W-1:0] stat_mispred;

  int checks   = 0;
  int failures = 0;

  bht_predictor #(.SETS(32), .TAG_W(20), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred),
    .stat_clr(stat_clr), .stat_hits(stat_hits), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check hit/taken/target for a PC in the current cycle.
  task automatic look(input string tag, input logic [31:0] pc, input logic h,
                      input logic t, input logic [31:0] tgt);
    lookup_pc = pc;
    #1;
    chk({tag, ".hit"}, 32'(pred_hit), 32'(h));
    chk({tag, ".taken"}, 32'(pred_taken), 32'(t));
    chk({tag, ".target"}, pred_target, tgt);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_mispred = mis;
    tick();
    upd_valid = 1'b0; upd_mispred = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; lookup_valid = 1'b0; lookup_pc = 32'h1010;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_mispred = 1'b0; stat_clr = 1'b0;
    tick(); tick();
    look("rst", 32'h1010, 1'b0, 1'b0, 32'h1014);
    chk("rst.stat_hits", 32'(stat_hits), 32'd0);
    chk("rst.stat_mispred", 32'(stat_mispred), 32'd0);
    rst_n = 1'b1;
    tick();

    // Allocate on taken
    look("empty", 32'h1010, 1'b0, 1'b0, 32'h1014);
    upd(32'h1010, 1'b1, 32'h2000, 1'b1);
    look("alloc", 32'h1010, 1'b1, 1'b1, 32'h2000);
    chk("alloc.stat_mispred", 32'(stat_mispred), 32'd1);

    // Counter saturation; not-taken updates must not overwrite the target
    upd(32'h1010, 1'b0, 32'h5000, 1'b0);
    upd(32'h1010, 1'b0, 32'h5000, 1'b0);
    look("nt2", 32'h1010, 1'b1, 1'b0, 32'h1014);
    for (int i = 0; i < 4; i++) upd(32'h1010, 1'b1, 32'h2000, 1'b0);
    look("t4", 32'h1010, 1'b1, 1'b1, 32'h2000);
    upd(32'h1010, 1'b0, 32'h5000, 1'b0);
    look("sat_nt1", 32'h1010, 1'b1, 1'b1, 32'h2000);
    upd(32'h1010, 1'b0, 32'h5000, 1'b0);
    look("sat_nt2", 32'h1010, 1'b1, 1'b0, 32'h1014);

    // No allocate on not-taken
    upd(32'h3000, 1'b0, 32'h6000, 1'b0);
    look("noalloc", 32'h3000, 1'b0, 1'b0, 32'h3004);

    // Flush, then LRU replacement in set 4
    flush = 1'b1; tick(); flush = 1'b0;
    look("flush1", 32'h1010, 1'b0, 1'b0, 32'h1014);
    upd(32'h1010, 1'b1, 32'hA000, 1'b0);
    upd(32'h1090, 1'b1, 32'hB000, 1'b0);
    look("way1", 32'h1090, 1'b1, 1'b1, 32'hB000);
    upd(32'h1010, 1'b1, 32'hA000, 1'b0);
    // Same-cycle lookup sees pre-update contents
    upd_valid = 1'b1; upd_pc = 32'h1110; upd_taken = 1'b1; upd_target = 32'hC000;
    look("nobypass", 32'h1110, 1'b0, 1'b0, 32'h1114);
    tick();
    upd_valid = 1'b0;
    look("lru_evict", 32'h1090, 1'b0, 1'b0, 32'h1094);
    look("lru_keep", 32'h1010, 1'b1, 1'b1, 32'hA000);
    look("lru_new", 32'h1110, 1'b1, 1'b1, 32'hC000);

    // Flush overrides a same-cycle taken update
    flush = 1'b1;
    upd(32'h4000, 1'b1, 32'h7000, 1'b0);
    flush = 1'b0;
    look("fl_a", 32'h1010, 1'b0, 1'b0, 32'h1014);
    look("fl_b", 32'h1110, 1'b0, 1'b0, 32'h1114);
    look("fl_c", 32'h4000, 1'b0, 1'b0, 32'h4004);
    chk("fl.stat_hits", 32'(stat_hits), 32'd0);
    chk("fl.stat_mispred", 32'(stat_mispred), 32'd1);

    // Statistics saturation and clear
    upd(32'h1010, 1'b1, 32'h2000, 1'b0);
    lookup_pc = 32'h1010; lookup_valid = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h3000; upd_taken = 1'b0; upd_mispred = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    upd_valid = 1'b0; upd_mispred = 1'b0;
    chk("sat.stat_hits", 32'(stat_hits), 32'd15);
    chk("sat.stat_mispred", 32'(stat_mispred), 32'd15);
    stat_clr = 1'b1; tick(); stat_clr = 1'b0; lookup_valid = 1'b0;
    chk("clr.stat_hits", 32'(stat_hits), 32'd0);
    chk("clr.stat_mispred", 32'(stat_mispred), 32'd0);

    // Asynchronous reset mid-operation drops a pending update
    upd_valid = 1'b1; upd_pc = 32'h1090; upd_taken = 1'b1; upd_target = 32'hB000;
    #2 rst_n = 1'b0;
    look("arst", 32'h1010, 1'b0, 1'b0, 32'h1014);
    tick();
    upd_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    look("arst_drop", 32'h1090, 1'b0, 1'b0, 32'h1094);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
